// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one outstanding imem read per accepted PC, results
// (or misaligned-PC faults) queued toward decode through a small circular FIFO.
module instr_fetch #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE_C  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO_C = (AW + 1)'(0);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO_C = AW'(0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     req_pc_q, req_pc_d;

  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic            fifo_fault_q [FIFO_DEPTH];

  logic            accept_s;
  logic            aligned_s;
  logic            push_s;
  logic            pop_s;
  logic [31:0]     push_pc_s;
  logic [31:0]     push_instr_s;
  logic            push_fault_s;

  // State, occupancy, pointers and the in-flight request PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= CNT_ZERO_C;
      wr_ptr_q <= PTR_ZERO_C;
      rd_ptr_q <= PTR_ZERO_C;
      req_pc_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      req_pc_q <= req_pc_d;
    end
  end

  // FIFO storage; contents past the head are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_pc_q[wr_ptr_q]    <= push_pc_s;
      fifo_instr_q[wr_ptr_q] <= push_instr_s;
      fifo_fault_q[wr_ptr_q] <= push_fault_s;
    end
  end

  // Next-state logic; an rvalid always retires the outstanding request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && aligned_s) state_d = WAIT;
        else                       state_d = IDLE;
      end
      WAIT: begin
        if (imem_rvalid) state_d = IDLE;
        else if (flush)  state_d = DROP;
        else             state_d = WAIT;
      end
      DROP: begin
        if (imem_rvalid) state_d = IDLE;
        else             state_d = DROP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Push/pop decisions and FIFO bookkeeping; flush overrides any push.
  always_comb begin
    aligned_s    = (pc_in[1:0] == 2'b00);
    accept_s     = pc_valid && pc_ready;
    pop_s        = if_valid && if_ready;
    push_s       = 1'b0;
    push_pc_s    = 32'h0;
    push_instr_s = 32'h0;
    push_fault_s = 1'b0;
    req_pc_d     = req_pc_q;
    if ((state_q == IDLE) && accept_s && !aligned_s) begin
      push_s       = !flush;
      push_pc_s    = pc_in;
      push_fault_s = 1'b1;
    end else if ((state_q == WAIT) && imem_rvalid) begin
      push_s       = !flush;
      push_pc_s    = req_pc_q;
      push_instr_s = imem_rdata;
    end else begin
      push_s       = 1'b0;
    end
    if (accept_s && aligned_s) req_pc_d = pc_in;
    else                       req_pc_d = req_pc_q;

    if (flush) begin
      count_d  = CNT_ZERO_C;
      wr_ptr_d = PTR_ZERO_C;
      rd_ptr_d = PTR_ZERO_C;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE_C;
        2'b01:   count_d = count_q - CNT_ONE_C;
        default: count_d = count_q;
      endcase
      if (push_s) wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      else        rd_ptr_d = rd_ptr_q;
    end
  end

  // Outputs: handshake and request are combinational, decode side reads the head.
  always_comb begin
    pc_ready  = (state_q == IDLE) && !flush && (count_q < DEPTH_C);
    imem_req  = 1'b0;
    imem_addr = 32'h0;
    if ((state_q == IDLE) && pc_valid && pc_ready && (pc_in[1:0] == 2'b00)) begin
      imem_req  = 1'b1;
      imem_addr = pc_in;
    end else begin
      imem_req  = 1'b0;
      imem_addr = 32'h0;
    end
    if_valid = (count_q != CNT_ZERO_C);
    if (if_valid) begin
      if_pc    = fifo_pc_q[rd_ptr_q];
      if_instr = fifo_instr_q[rd_ptr_q];
      if_fault = fifo_fault_q[rd_ptr_q];
    end else begin
      if_pc    = 32'h0;
      if_instr = 32'h0;
      if_fault = 1'b0;
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage directly downstream of `pc_control`. Takes the 32-bit program counter that `pc_control` drives on `out_pc`, issues one instruction-memory read per PC with at most one request outstanding, and pushes each {pc, instruction} pair into a small FIFO that the decode stage drains with a valid/ready handshake. Also supports a flush for redirects and reports misaligned PCs without touching memory.

## Interface
- `FIFO_DEPTH`, default 2: number of fetched-instruction entries buffered toward decode. Must be a power of two and at least 2.
- `clk`  in  1  single clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  PC to fetch; connected to `pc_control.out_pc`.
- `pc_valid`  in  1  `pc_in` is meaningful this cycle.
- `pc_ready`  out  1  fetch accepts `pc_in` this cycle; a transfer occurs when `pc_valid && pc_ready`.
- `flush`  in  1  discard all buffered and in-flight fetches.
- `imem_req`  out  1  single-cycle read request to instruction memory.
- `imem_addr`  out  32  read address; equals `pc_in` while `imem_req` is high.
- `imem_rvalid`  in  1  read data valid; asserted for exactly one cycle per request, 1 or more cycles after `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `if_valid`  out  1  FIFO head holds an entry.
- `if_ready`  in  1  decode consumes the head; a pop occurs when `if_valid && if_ready`.
- `if_pc`  out  32  PC of the head entry.
- `if_instr`  out  32  instruction of the head entry.
- `if_fault`  out  1  the head entry came from a misaligned PC.

## Operation
- **FSM states:** IDLE, WAIT, DROP.
- **IDLE:**
  - `pc_ready = !flush && count < FIFO_DEPTH`, where `count` is the registered occupancy.
  - Aligned PC accepted (`pc_in[1:0]==0`):
    - `imem_req=1` combinationally and `imem_addr=pc_in`.
    - `pc_in` is latched into `req_pc`.
    - The FSM moves to WAIT.
  - Misaligned PC accepted:
    - No memory request is issued.
    - The FIFO is pushed with {`pc_in`, 32'h0, fault=1}.
    - The FSM stays in IDLE.
- **WAIT:**
  - `pc_ready=0`.
  - On `imem_rvalid`, push {`req_pc`, `imem_rdata`, fault=0} and go to IDLE. The FIFO is guaranteed to have room, because the request was only issued when `count < FIFO_DEPTH`.
- **DROP:**
  - `pc_ready=0`.
  - On `imem_rvalid`, discard the data and go to IDLE.
- **flush:**
  - The FIFO is emptied: `count` becomes 0 and the pointers are reset.
  - Any push in that same cycle is suppressed.
  - In IDLE, the FSM stays in IDLE.
  - In WAIT with `imem_rvalid=0`, the FSM goes to DROP.
  - In WAIT with `imem_rvalid=1` in the same cycle, the data is discarded and the FSM goes to IDLE.
  - In DROP, the FSM remains in DROP until `rvalid` arrives.
- **FIFO:**
  - Circular buffer with read and write pointers of log2(`FIFO_DEPTH`) bits that wrap naturally, plus a `count` of log2(`FIFO_DEPTH`)+1 bits.
  - Push and pop in the same cycle leave `count` unchanged.
  - The `if_*` outputs come from the head register or array with no combinational path from `imem_rdata`.
- The `pc_ready` full check uses the registered `count`. A pop in the same cycle does not make room until the next cycle.

## Timing
- **Reset values:**
  - FSM in IDLE, `count=0`, pointers 0.
  - `if_valid=0`, `if_pc=0`, `if_instr=0`, `if_fault=0`.
  - `imem_req=0`, `imem_addr=0` (both are driven as 0 whenever no request is issued).
  - `pc_ready=1`, unless `flush` is high.
- **Reset mid-operation:** reset wins over everything. An `imem_rvalid` arriving after reset from a pre-reset request is ignored, because the FSM is in IDLE.
- **Latency:**
  - PC accepted in cycle N gives `imem_req` in cycle N.
  - With `imem_rvalid` in cycle N+k, `if_valid=1` in cycle N+k+1.
  - Misaligned PC accepted in cycle N gives `if_valid` in cycle N+1.
- **Throughput:**
  - With 1-cycle memory, one fetch every 2 cycles (IDLE→WAIT→IDLE).
  - Back-to-back misaligned PCs go at 1 per cycle.
- `flush` takes effect on the clock edge it is sampled at: `if_valid=0` in the following cycle.

## Test plan
- **Basic fetch:** 1-cycle memory, PCs 0x0, 0x4, 0x8 with `rdata = pc ^ 32'hA5A5_0000` and `if_ready=1`.
  - `imem_req` pulses every 2 cycles.
  - Decode sees (0x0,0xA5A50000), (0x4,0xA5A50004), (0x8,0xA5A50008) in order, each with `if_fault=0`.
- **Back-pressure:** `FIFO_DEPTH=2`, `if_ready=0`, continuous `pc_valid`.
  - After 2 completed fetches, `count=2` and `pc_ready=0`, with no further `imem_req`.
  - Raise `if_ready` for one cycle: one pop, then `pc_ready=1` the next cycle.
- **Misaligned:** `pc_in=0x102`.
  - No `imem_req`.
  - Next cycle: `if_valid=1`, `if_pc=0x102`, `if_instr=0`, `if_fault=1`.
- **Flush in WAIT:** 3-cycle memory latency, `flush` asserted the cycle after `imem_req` for PC 0x20.
  - FSM goes to DROP, and the returning data is never seen by decode.
  - The next PC 0x40 is accepted only after that `rvalid`, and decode receives only 0x40.
- **Flush coincident with rvalid:** 1 buffered entry, then flush in the same cycle as `imem_rvalid`.
  - `if_valid=0` the next cycle.
  - FSM is in IDLE and `pc_ready=1`.
- **Reset mid-operation:** assert `rst` while in WAIT with 2 entries buffered.
  - All outputs take their reset values the next cycle.
  - A late `imem_rvalid` produces no entry.
